data_mem_ctrl: RTL and testbench

Load/store controller sitting directly downstream of risc_v_32's data port. It takes one CPU load or store request, which carries the same address and data as D_OUT_ADDR, D_OUT and WR. It converts the request into accesses on a word-wide synchronous SRAM with byte enables, and returns lane-aligned, sign- or zero-extended load data with a completion pulse. Misaligned and out-of-range accesses are rejected with an error pulse and no memory access.

---
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Load/store controller: turns one CPU byte/half/word request into a single
// byte-enabled SRAM word access. Load data comes back lane-aligned and
// extended. Misaligned and out-of-range requests are rejected with no access.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [31:0]       ADDR,
    input  logic [31:0]       WDATA,
    input  logic [1:0]        SIZE,
    input  logic              UNS,
    output logic [31:0]       RDATA,
    output logic              READY,
    output logic              ERR,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [3:0]        MEM_BE,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RDWAIT = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t      state;
    logic        cap_we;
    logic        cap_uns;
    logic [1:0]  cap_size;
    logic [1:0]  cap_lo;

    logic        req_fault;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Request decode; only ever consumed by registers at acceptance.
    always_comb begin
        req_fault = (SIZE == SZ_ILL)
                  | ((SIZE == SZ_HALF) & ADDR[0])
                  | ((SIZE == SZ_WORD) & (ADDR[1:0] != 2'b00))
                  | ((ADDR >> (ADDR_W + 2)) != 32'd0);
        case (SIZE)
            SZ_BYTE: req_be = 4'b0001 << ADDR[1:0];
            SZ_HALF: req_be = 4'b0011 << {ADDR[1], 1'b0};
            default: req_be = 4'b1111;
        endcase
        req_wdata = WDATA << {ADDR[1:0], 3'b000};
    end

    // Lane select and sign/zero extension of the SRAM read word.
    always_comb begin
        rd_byte = 8'(MEM_RDATA >> {cap_lo, 3'b000});
        rd_half = 16'(MEM_RDATA >> {cap_lo[1], 4'b0000});
        case (cap_size)
            SZ_BYTE: rd_ext = cap_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_ext = cap_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = MEM_RDATA;
        endcase
    end

    // Controller FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_uns   <= 1'b0;
            cap_size  <= 2'b00;
            cap_lo    <= 2'b00;
            RDATA     <= 32'd0;
            READY     <= 1'b0;
            ERR       <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_BE    <= 4'd0;
            MEM_WDATA <= 32'd0;
        end else begin
            READY     <= 1'b0;
            ERR       <= 1'b0;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_BE    <= 4'd0;
            MEM_WDATA <= 32'd0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        cap_we   <= WE;
                        cap_uns  <= UNS;
                        cap_size <= SIZE;
                        cap_lo   <= ADDR[1:0];
                        if (req_fault) begin
                            READY <= 1'b1;
                            ERR   <= 1'b1;
                            state <= FAULT;
                        end else begin
                            MEM_EN    <= 1'b1;
                            MEM_WE    <= WE;
                            MEM_ADDR  <= ADDR[ADDR_W+1:2];
                            MEM_BE    <= req_be;
                            MEM_WDATA <= req_wdata;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cap_we) begin
                        READY <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    RDATA <= rd_ext;
                    READY <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural byte-enabled SRAM.
module tb_data_mem_ctrl;

    localparam int unsigned ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic              REQ;
    logic              WE;
    logic [31:0]       ADDR;
    logic [31:0]       WDATA;
    logic [1:0]        SIZE;
    logic              UNS;
    logic [31:0]       RDATA;
    logic              READY;
    logic              ERR;
    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [3:0]        MEM_BE;
    logic [31:0]       MEM_WDATA;
    logic [31:0]       MEM_RDATA;

    int tests = 0;
    int fails = 0;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pre_en = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [31:0]       pre_data = 32'd0;
    logic              en_seen;

    data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .SIZE(SIZE), .UNS(UNS), .RDATA(RDATA), .READY(READY), .ERR(ERR),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    // Synchronous SRAM with byte enables plus a preload port for the bench.
    always @(posedge CLK) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (MEM_EN) begin
            if (MEM_WE) begin
                for (int i = 0; i < 4; i++)
                    if (MEM_BE[i]) mem[MEM_ADDR][8*i +: 8] <= MEM_WDATA[8*i +: 8];
            end else begin
                MEM_RDATA <= mem[MEM_ADDR];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_en   = 1'b1;
        tick();
        pre_en   = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns);
        REQ = 1'b1; WE = we; ADDR = a; WDATA = wd; SIZE = sz; UNS = uns;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, RDATA, 32'd0);
        chk({tag, "_ready"}, {31'd0, READY}, 32'd0);
        chk({tag, "_err"}, {31'd0, ERR}, 32'd0);
        chk({tag, "_en"}, {31'd0, MEM_EN}, 32'd0);
        chk({tag, "_we"}, {31'd0, MEM_WE}, 32'd0);
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, "_be"}, {28'd0, MEM_BE}, 32'd0);
        chk({tag, "_wdata"}, MEM_WDATA, 32'd0);
    endtask

    task automatic load_word(input logic [31:0] a, input logic uns, input logic [1:0] sz,
                             input logic [3:0] be, input logic [31:0] exp, input string tag);
        drive(1'b0, a, 32'd0, sz, uns);
        tick();
        REQ = 1'b0;
        chk({tag, "_c1_en"}, {31'd0, MEM_EN}, 32'd1);
        chk({tag, "_c1_be"}, {28'd0, MEM_BE}, {28'd0, be});
        chk({tag, "_c1_we"}, {31'd0, MEM_WE}, 32'd0);
        tick();
        chk({tag, "_c2_rdy"}, {31'd0, READY}, 32'd0);
        chk({tag, "_c2_en"}, {31'd0, MEM_EN}, 32'd0);
        tick();
        chk({tag, "_c3_rdy"}, {31'd0, READY}, 32'd1);
        chk({tag, "_c3_err"}, {31'd0, ERR}, 32'd0);
        chk({tag, "_c3_rdata"}, RDATA, exp);
        tick();
    endtask

    task automatic fault_case(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] rd_hold, input string tag);
        drive(we, a, 32'hFFFF_FFFF, sz, 1'b0);
        en_seen = 1'b0;
        tick();
        REQ = 1'b0;
        en_seen = en_seen | MEM_EN;
        chk({tag, "_rdy"}, {31'd0, READY}, 32'd1);
        chk({tag, "_err"}, {31'd0, ERR}, 32'd1);
        chk({tag, "_rdata"}, RDATA, rd_hold);
        tick();
        en_seen = en_seen | MEM_EN;
        chk({tag, "_rdy_off"}, {30'd0, READY, ERR}, 32'd0);
        chk({tag, "_en_never"}, {31'd0, en_seen}, 32'd0);
    endtask

    initial begin
        RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = 32'd0; WDATA = 32'd0;
        SIZE = 2'b00; UNS = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        RST = 1'b0;
        tick();

        // Word store
        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        tick();
        REQ = 1'b0;
        chk("ws_en", {31'd0, MEM_EN}, 32'd1);
        chk("ws_we", {31'd0, MEM_WE}, 32'd1);
        chk("ws_addr", 32'(MEM_ADDR), 32'd4);
        chk("ws_be", {28'd0, MEM_BE}, 32'hF);
        chk("ws_wdata", MEM_WDATA, 32'hDEAD_BEEF);
        chk("ws_c1_rdy", {31'd0, READY}, 32'd0);
        tick();
        chk("ws_c2_rdy", {31'd0, READY}, 32'd1);
        chk("ws_c2_err", {31'd0, ERR}, 32'd0);
        chk("ws_c2_en", {31'd0, MEM_EN}, 32'd0);
        chk("ws_rdata", RDATA, 32'd0);
        tick();
        chk("ws_rdy_off", {31'd0, READY}, 32'd0);
        chk("ws_mem", mem[4], 32'hDEAD_BEEF);

        // Byte loads from lane 3, signed then unsigned
        preload(10'd4, 32'h80FF_0102);
        load_word(32'h13, 1'b0, 2'b00, 4'b1000, 32'hFFFF_FF80, "lbs");
        load_word(32'h13, 1'b1, 2'b00, 4'b1000, 32'h0000_0080, "lbu");
        load_word(32'h11, 1'b0, 2'b00, 4'b0010, 32'h0000_0001, "lb1");

        // Half store to upper lanes, then read it back signed and unsigned
        drive(1'b1, 32'h22, 32'h0000_ABCD, 2'b01, 1'b0);
        tick();
        REQ = 1'b0;
        chk("hs_addr", 32'(MEM_ADDR), 32'd8);
        chk("hs_be", {28'd0, MEM_BE}, 32'hC);
        chk("hs_wdata", MEM_WDATA, 32'hABCD_0000);
        tick();
        chk("hs_rdy", {31'd0, READY}, 32'd1);
        chk("hs_rdata", RDATA, 32'h0000_0001);
        tick();
        chk("hs_mem", mem[8], 32'hABCD_0000);
        load_word(32'h22, 1'b0, 2'b01, 4'b1100, 32'hFFFF_ABCD, "lhs");
        load_word(32'h20, 1'b1, 2'b01, 4'b0011, 32'h0000_0000, "lhu");

        // Highest valid word
        preload(10'd1023, 32'h1234_5678);
        load_word(32'hFFC, 1'b0, 2'b10, 4'b1111, 32'h1234_5678, "ltop");

        // Faults leave RDATA alone and never touch the SRAM
        fault_case(1'b0, 32'h6, 2'b10, 32'h1234_5678, "f_mis_w");
        fault_case(1'b1, 32'h0, 2'b11, 32'h1234_5678, "f_size");
        fault_case(1'b0, 32'h0000_1000, 2'b10, 32'h1234_5678, "f_range");
        fault_case(1'b1, 32'h21, 2'b01, 32'h1234_5678, "f_mis_h");
        chk("f_mem_intact", mem[8], 32'hABCD_0000);

        // Back-to-back loads with REQ held high
        preload(10'd0, 32'h1111_1111);
        preload(10'd1, 32'h2222_2222);
        drive(1'b0, 32'h0, 32'd0, 2'b10, 1'b0);
        tick();
        chk("bb_c1_en", {31'd0, MEM_EN}, 32'd1);
        chk("bb_c1_addr", 32'(MEM_ADDR), 32'd0);
        ADDR = 32'h4;
        tick();
        chk("bb_c2_en", {31'd0, MEM_EN}, 32'd0);
        tick();
        chk("bb_c3_rdy", {31'd0, READY}, 32'd1);
        chk("bb_c3_rdata", RDATA, 32'h1111_1111);
        tick();
        chk("bb_c4_en", {31'd0, MEM_EN}, 32'd0);
        chk("bb_c4_rdata", RDATA, 32'h1111_1111);
        tick();
        REQ = 1'b0;
        chk("bb_c5_en", {31'd0, MEM_EN}, 32'd1);
        chk("bb_c5_addr", 32'(MEM_ADDR), 32'd1);
        tick();
        tick();
        chk("bb_c7_rdy", {31'd0, READY}, 32'd1);
        chk("bb_c7_rdata", RDATA, 32'h2222_2222);
        tick();

        // Reset in RDWAIT aborts the load
        drive(1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
        tick();
        REQ = 1'b0;
        chk("rst_c1_en", {31'd0, MEM_EN}, 32'd1);
        tick();
        RST = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        tick();
        RST = 1'b0;
        tick();
        chk("rst_no_rdy1", {31'd0, READY}, 32'd0);
        tick();
        chk("rst_no_rdy2", {31'd0, READY}, 32'd0);
        load_word(32'h20, 1'b0, 2'b10, 4'b1111, 32'hABCD_0000, "rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
